// File: rtl/cronometro_defs.sv
// Shared definitions for the stopwatch controller: FSM state encoding,
// default debounce length and the packed BCD time record.
package cronometro_defs;

   localparam int unsigned DEB_CICLOS_PADRAO = 3;

   typedef enum logic [1:0] {
      PARADO   = 2'd0,
      CONTANDO = 2'd1,
      PAUSADO  = 2'd2,
      PARCIAL  = 2'd3
   } estado_t;

   // Digit order matches the display: s_d:s_u . cs_d:cs_u
   typedef struct packed {
      logic [3:0] s_d;
      logic [3:0] s_u;
      logic [3:0] cs_d;
      logic [3:0] cs_u;
   } tempo_t;

   // Counter runs in both CONTANDO and PARCIAL
   function automatic logic conta(input estado_t e);
      return (e == CONTANDO) || (e == PARCIAL);
   endfunction

endpackage

// File: rtl/detector_botao.sv
// Push-button front end: 2-flop synchronizer, stability filter and
// press (1->0) edge detector producing a registered one-cycle pulse.
// A key already held when reset is released is ignored until it has
// been seen released.
module detector_botao
   import cronometro_defs::*;
#(
   parameter int unsigned DEB_CICLOS = DEB_CICLOS_PADRAO
)
(
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic press
);

   localparam int unsigned   CW     = (DEB_CICLOS > 2) ? $clog2(DEB_CICLOS) : 1;
   localparam logic [CW-1:0] ULTIMO = CW'(DEB_CICLOS - 1);

   logic          sinc1;
   logic          sinc2;
   logic          valido1;
   logic          valido2;
   logic          armado;
   logic          nivel;
   logic [CW-1:0] cont;

   // Synchronizer chain plus a parallel flag marking when sinc2 holds a real key sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sinc1   <= 1'b1;
         sinc2   <= 1'b1;
         valido1 <= 1'b0;
         valido2 <= 1'b0;
      end else begin
         sinc1   <= key_n;
         sinc2   <= sinc1;
         valido1 <= 1'b1;
         valido2 <= valido1;
      end
   end

   // Events are enabled only after a genuine released sample following reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armado <= 1'b0;
      end else if (valido2 && sinc2) begin
         armado <= 1'b1;
      end
   end

   // Stability filter: accept a new level after DEB_CICLOS equal samples; pulse on press
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nivel <= 1'b1;
         cont  <= '0;
         press <= 1'b0;
      end else begin
         press <= 1'b0;
         if (sinc2 == nivel) begin
            cont <= '0;
         end else if (cont == ULTIMO) begin
            nivel <= sinc2;
            cont  <= '0;
            press <= armado & ~sinc2;
         end else begin
            cont <= cont + 1'b1;
         end
      end
   end

endmodule

// File: rtl/controle_cronometro.sv
// Stopwatch controller: debounced keys drive a 4-state FSM that enables
// the external BCD counter, issues a one-cycle registered clear, and
// optionally freezes the displayed time on lap.
// Optional feature: define CRONOMETRO_LAP_EN to build the lap key,
// PARCIAL state and the display latch.
module controle_cronometro
   import cronometro_defs::*;
#(
   parameter int unsigned DEB_CICLOS = DEB_CICLOS_PADRAO
)
(
   input  logic       clk_100hz,
   input  logic       reset,
   input  logic       key_start_stop_n,
   input  logic       key_lap_n,
   input  logic       key_clear_n,
   input  logic [3:0] cs_unidade,
   input  logic [3:0] cs_dezena,
   input  logic [3:0] s_unidade,
   input  logic [3:0] s_dezena,
   output logic       cnt_enable,
   output logic       cnt_clear_n,
   output logic [3:0] disp_cs_u,
   output logic [3:0] disp_cs_d,
   output logic [3:0] disp_s_u,
   output logic [3:0] disp_s_d,
   output logic       led_contando,
   output logic       led_parcial
);

   estado_t estado;
   estado_t prox;
   logic    ev_start;
   logic    ev_clear;
   logic    ev_lap;
   logic    pede_clear;
   tempo_t  vivo;
   tempo_t  mostrado;

   assign vivo = {s_dezena, s_unidade, cs_dezena, cs_unidade};

   detector_botao #(.DEB_CICLOS(DEB_CICLOS)) u_start (
      .clk   (clk_100hz),
      .rst_n (reset),
      .key_n (key_start_stop_n),
      .press (ev_start)
   );

   detector_botao #(.DEB_CICLOS(DEB_CICLOS)) u_clear (
      .clk   (clk_100hz),
      .rst_n (reset),
      .key_n (key_clear_n),
      .press (ev_clear)
   );

`ifdef CRONOMETRO_LAP_EN
   logic   pede_latch;
   tempo_t congelado;

   detector_botao #(.DEB_CICLOS(DEB_CICLOS)) u_lap (
      .clk   (clk_100hz),
      .rst_n (reset),
      .key_n (key_lap_n),
      .press (ev_lap)
   );
`else
   logic unused_lap;

   assign unused_lap = key_lap_n;
   assign ev_lap     = 1'b0;
`endif

   // State register
   always_ff @(posedge clk_100hz or negedge reset) begin
      if (!reset) begin
         estado <= PARADO;
      end else begin
         estado <= prox;
      end
   end

   // Counter clear is re-timed through a flop so the pulse is glitch-free
   always_ff @(posedge clk_100hz or negedge reset) begin
      if (!reset) begin
         cnt_clear_n <= 1'b1;
      end else begin
         cnt_clear_n <= ~pede_clear;
      end
   end

   // Next state: the highest-priority event of the cycle is the only one considered
   always_comb begin
      prox       = estado;
      pede_clear = 1'b0;
`ifdef CRONOMETRO_LAP_EN
      pede_latch = 1'b0;
`endif
      if (ev_clear) begin
         if ((estado == PARADO) || (estado == PAUSADO)) begin
            prox       = PARADO;
            pede_clear = 1'b1;
         end
      end else if (ev_start) begin
         case (estado)
            PARADO, PAUSADO:  prox = CONTANDO;
            CONTANDO, PARCIAL: prox = PAUSADO;
            default:          prox = estado;
         endcase
      end else if (ev_lap) begin
`ifdef CRONOMETRO_LAP_EN
         case (estado)
            CONTANDO: begin
               prox       = PARCIAL;
               pede_latch = 1'b1;
            end
            PARCIAL:  prox = CONTANDO;
            default:  prox = estado;
         endcase
`else
         prox = estado;
`endif
      end
   end

`ifdef CRONOMETRO_LAP_EN
   // Lap latch captures the live digits on the same edge that enters PARCIAL
   always_ff @(posedge clk_100hz or negedge reset) begin
      if (!reset) begin
         congelado <= '0;
      end else if (pede_latch) begin
         congelado <= vivo;
      end
   end

   assign mostrado    = (estado == PARCIAL) ? congelado : vivo;
   assign led_parcial = (estado == PARCIAL);
`else
   assign mostrado    = vivo;
   assign led_parcial = 1'b0;
`endif

   assign cnt_enable   = conta(estado);
   assign led_contando = cnt_enable;

   assign {disp_s_d, disp_s_u, disp_cs_d, disp_cs_u} = mostrado;

endmodule

// File: tb/tb_controle_cronometro.sv
// Directed, table-driven bench for controle_cronometro. Expectations
// adapt to whether CRONOMETRO_LAP_EN is defined for the build.
`timescale 1ns/1ps
module tb_controle_cronometro;

`ifdef CRONOMETRO_LAP_EN
   localparam bit LAP = 1'b1;
`else
   localparam bit LAP = 1'b0;
`endif

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        k_ss  = 1'b1;
   logic        k_lap = 1'b1;
   logic        k_clr = 1'b1;
   logic [15:0] live  = 16'h0102;

   logic        cnt_enable;
   logic        cnt_clear_n;
   logic [3:0]  disp_cs_u;
   logic [3:0]  disp_cs_d;
   logic [3:0]  disp_s_u;
   logic [3:0]  disp_s_d;
   logic        led_contando;
   logic        led_parcial;

   always #5 clk = ~clk;

   controle_cronometro #(.DEB_CICLOS(3)) dut (
      .clk_100hz        (clk),
      .reset            (rst_n),
      .key_start_stop_n (k_ss),
      .key_lap_n        (k_lap),
      .key_clear_n      (k_clr),
      .cs_unidade       (live[3:0]),
      .cs_dezena        (live[7:4]),
      .s_unidade        (live[11:8]),
      .s_dezena         (live[15:12]),
      .cnt_enable       (cnt_enable),
      .cnt_clear_n      (cnt_clear_n),
      .disp_cs_u        (disp_cs_u),
      .disp_cs_d        (disp_cs_d),
      .disp_s_u         (disp_s_u),
      .disp_s_d         (disp_s_d),
      .led_contando     (led_contando),
      .led_parcial      (led_parcial)
   );

   wire [15:0] disp = {disp_s_d, disp_s_u, disp_cs_d, disp_cs_u};

   int   total = 0;
   int   bad   = 0;
   int   pulses = 0;
   int   en_changes = 0;
   logic en_prev = 1'b0;

   // Count low samples of the clear strobe and enable transitions
   always @(negedge clk) begin
      if (!cnt_clear_n) pulses++;
      if (cnt_enable !== en_prev) en_changes++;
      en_prev = cnt_enable;
   end

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic set_key(input int k, input logic v);
      case (k)
         0: k_ss  = v;
         1: k_lap = v;
         2: k_clr = v;
         default: ;
      endcase
   endtask

   task automatic press(input int k);
      set_key(k, 1'b0);
      tick(8);
      set_key(k, 1'b1);
      tick(8);
   endtask

   typedef struct {
      int          key;     // 0 start_stop, 1 lap, 2 clear, 3 none
      logic [15:0] live;
      logic        en;
      logic        lp;
      int          pulses;
      logic [15:0] disp;
   } vec_t;

   vec_t tab[14];

   initial begin
      int p0;
      int c0;

      tab[0]  = '{0, 16'h0010, 1'b0, 1'b0, 0, 16'h0010};
      tab[1]  = '{1, 16'h0010, 1'b0, 1'b0, 0, 16'h0010};
      tab[2]  = '{0, 16'h0020, 1'b1, 1'b0, 0, 16'h0020};
      tab[3]  = '{2, 16'h0030, 1'b1, 1'b0, 0, 16'h0030};
      tab[4]  = '{1, 16'h1234, 1'b1, LAP,  0, 16'h1234};
      tab[5]  = '{3, 16'h1500, 1'b1, LAP,  0, LAP ? 16'h1234 : 16'h1500};
      tab[6]  = '{1, 16'h1501, 1'b1, 1'b0, 0, 16'h1501};
      tab[7]  = '{0, 16'h1502, 1'b0, 1'b0, 0, 16'h1502};
      tab[8]  = '{2, 16'h1503, 1'b0, 1'b0, 1, 16'h1503};
      tab[9]  = '{2, 16'h1504, 1'b0, 1'b0, 1, 16'h1504};
      tab[10] = '{0, 16'h0000, 1'b1, 1'b0, 0, 16'h0000};
      tab[11] = '{1, 16'h5999, 1'b1, LAP,  0, 16'h5999};
      tab[12] = '{3, 16'h0000, 1'b1, LAP,  0, LAP ? 16'h5999 : 16'h0000};
      tab[13] = '{0, 16'h0001, 1'b0, 1'b0, 0, 16'h0001};

      // Reset state
      tick(3);
      chk("rst_en", cnt_enable, 1'b0);
      chk("rst_clear_n", cnt_clear_n, 1'b1);
      chk("rst_led_c", led_contando, 1'b0);
      chk("rst_led_p", led_parcial, 1'b0);
      chk("rst_disp", disp, 16'h0102);
      rst_n = 1'b1;
      tick(3);

      // Start latency: 2 sync + 3 filter + 1 state edge
      live = 16'h0000;
      k_ss = 1'b0;
      tick(5);
      chk("lat_en_edge5", cnt_enable, 1'b0);
      tick(1);
      chk("lat_en_edge6", cnt_enable, 1'b1);
      chk("lat_led_c", led_contando, 1'b1);
      tick(2);
      k_ss = 1'b1;
      tick(8);

      // Table of single presses starting from CONTANDO
      for (int i = 0; i < 14; i++) begin
         live = tab[i].live;
         p0   = pulses;
         if (tab[i].key < 3) press(tab[i].key);
         else tick(8);
         chk($sformatf("v%0d_en", i), cnt_enable, tab[i].en);
         chk($sformatf("v%0d_led_c", i), led_contando, tab[i].en);
         chk($sformatf("v%0d_led_p", i), led_parcial, tab[i].lp);
         chk($sformatf("v%0d_disp", i), disp, tab[i].disp);
         chk($sformatf("v%0d_pulses", i), 16'(pulses - p0), 16'(tab[i].pulses));
      end

      // Simultaneous clear and start_stop in PAUSADO: clear wins
      p0 = pulses;
      c0 = en_changes;
      k_ss  = 1'b0;
      k_clr = 1'b0;
      tick(8);
      k_ss  = 1'b1;
      k_clr = 1'b1;
      tick(8);
      chk("simul_en", cnt_enable, 1'b0);
      chk("simul_en_changes", 16'(en_changes - c0), 16'd0);
      chk("simul_pulses", 16'(pulses - p0), 16'd1);

      // Bouncing start_stop followed by a stable press: one event
      c0 = en_changes;
      for (int i = 0; i < 10; i++) begin
         k_ss = (i % 2 == 0) ? 1'b0 : 1'b1;
         tick(1);
      end
      k_ss = 1'b0;
      tick(8);
      k_ss = 1'b1;
      tick(8);
      chk("bounce_en", cnt_enable, 1'b1);
      chk("bounce_en_changes", 16'(en_changes - c0), 16'd1);

      // Enter PARCIAL when built with lap, then reset mid-cycle
      live = 16'h2222;
      press(1);
      chk("pre_rst_led_p", led_parcial, LAP);
      live = 16'h4242;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_en", cnt_enable, 1'b0);
      chk("mid_rst_led_c", led_contando, 1'b0);
      chk("mid_rst_led_p", led_parcial, 1'b0);
      chk("mid_rst_disp", disp, 16'h4242);
      chk("mid_rst_clear_n", cnt_clear_n, 1'b1);

      // Key held through reset release must not start the count
      k_ss = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(20);
      chk("held_rst_en", cnt_enable, 1'b0);
      k_ss = 1'b1;
      tick(8);
      chk("held_rel_en", cnt_enable, 1'b0);
      press(0);
      chk("held_repress_en", cnt_enable, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/controle_cronometro.md
CONTROLE_CRONOMETRO -- requirements
Module: controle_cronometro

Interface
REQ-001 SHALL have parameter DEB_CICLOS, default 3, meaning consecutive equal synchronized samples needed to accept a key level (30 ms at 100 Hz).
REQ-002 SHALL have port clk_100hz  in  1  sole clock, 100 Hz from divisor_clock.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports key_start_stop_n, key_lap_n, key_clear_n  in  1 each  raw asynchronous push-buttons, pressed = 0.
REQ-005 SHALL have ports cs_unidade, cs_dezena, s_unidade, s_dezena  in  4 each  live BCD count from the stopwatch counter.
REQ-006 SHALL have port cnt_enable  out  1  counting enable to the counter.
REQ-007 SHALL have port cnt_clear_n  out  1  registered active-low clear to the counter's reset.
REQ-008 SHALL have ports disp_cs_u, disp_cs_d, disp_s_u, disp_s_d  out  4 each  BCD digits for HEX0..HEX3.
REQ-009 SHALL have ports led_contando, led_parcial  out  1 each  status indicators.

Function
REQ-010 Each key SHALL pass a 2-flop synchronizer, then a stability filter: debounced level changes only after DEB_CICLOS consecutive synchronized samples at the new value.
REQ-011 A press event SHALL be a one-cycle pulse on a debounced 1->0 transition; release generates nothing; a held key generates exactly one event.
REQ-012 The FSM SHALL have states PARADO, CONTANDO, PAUSADO, PARCIAL, encoded 2 bits.
REQ-013 PARADO: start_stop -> CONTANDO; clear -> PARADO with clear pulse; lap ignored.
REQ-014 CONTANDO: start_stop -> PAUSADO; lap -> PARCIAL and latch the four live input digits in the same edge; clear ignored.
REQ-015 PARCIAL: counting continues; lap -> CONTANDO; start_stop -> PAUSADO; clear ignored.
REQ-016 PAUSADO: start_stop -> CONTANDO; clear -> PARADO with clear pulse; lap ignored.
REQ-017 Simultaneous events in one cycle SHALL resolve by priority clear > start_stop > lap; lower-priority events in that cycle are discarded.
REQ-018 cnt_enable SHALL be 1 exactly in CONTANDO and PARCIAL, decoded from the state register (state change and enable change on the same edge).
REQ-019 cnt_clear_n SHALL drive 0 for exactly one cycle, from a flop, the edge after an accepted clear; glitch-free.
REQ-020 disp_* SHALL show latched digits in PARCIAL, live inputs otherwise, combinational mux.
REQ-021 led_contando = cnt_enable; led_parcial = 1 only in PARCIAL.
REQ-022 Event-to-state latency SHALL be 2 sync + DEB_CICLOS + 1 cycles from stable key change.
REQ-023 Counter wrap 59:99 -> 00:00 SHALL not affect controller state.

Reset
REQ-024 On reset low, asynchronously: state PARADO, cnt_enable 0, cnt_clear_n 1, latched digits 0, synchronizers and debounced levels 1 (released), filter counters 0, leds 0.
REQ-025 A key held through reset release SHALL not produce an event until released and pressed again.

Configuration
REQ-026 Macro CRONOMETRO_LAP_EN defined: key_lap_n, PARCIAL and the latch are implemented per REQ-014/015/020.
REQ-027 Macro undefined: key_lap_n unused, no lap debouncer, PARCIAL unreachable, latch absent, led_parcial 0, disp_* always live.

Structure
REQ-028 State encodings and default DEB_CICLOS SHALL live in shared package/header cronometro_defs.
REQ-029 Synchronizer, filter and edge detect SHALL be sub-module detector_botao, instantiated once per key.

Verification
REQ-030 Reset, press start_stop 5 cycles -> cnt_enable 1 at cycle 2+3+1 after press; led_contando 1.
REQ-031 Running, press start_stop, then clear -> PAUSADO, enable 0; cnt_clear_n low exactly 1 cycle; state PARADO.
REQ-032 Running, inputs 12:34, press lap -> disp shows 12:34 while inputs advance to 15:00; second lap -> disp live 15:xx.
REQ-033 Bounce start_stop 0/1 each cycle for 10 cycles then stable 0 -> exactly one event.
REQ-034 clear and start_stop events same cycle in PAUSADO -> PARADO, clear pulse, enable stays 0.
REQ-035 Assert reset mid-PARCIAL -> immediate PARADO, disp live, enable 0; build without CRONOMETRO_LAP_EN, lap press -> no change.
